// File: rtl/alu_result_stage.sv
// alu_result_stage: picks the ALU result, resolves branches/jumps and registers the beat into a 2-entry skid buffer.
// Optional misaligned-target trap enabled by defining ALU_RESULT_MISALIGN_TRAP_EN.
module alu_result_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [6:0]            in_opcode,
   input  logic [2:0]            in_funct3,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [XLEN-1:0]       in_pc,
   input  logic [XLEN-1:0]       in_imm,
   input  logic [XLEN-1:0]       in_rs1,
   input  logic [XLEN-1:0]       in_rs2,
   input  logic [XLEN-1:0]       adder_rsv,
   input  logic [XLEN-1:0]       shifter_rsv,
   input  logic [XLEN-1:0]       comparator_rsv,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic [XLEN-1:0]       out_wdata,
   output logic                  out_we,
   output logic                  out_redirect,
   output logic [XLEN-1:0]       out_target,
   output logic                  out_trap
);
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       wdata;
      logic                  we;
      logic                  redirect;
      logic [XLEN-1:0]       target;
      logic                  trap;
   } beat_t;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   logic            w_eq, w_lt, w_ltu, w_taken, w_accept, w_retire;
   logic [XLEN-1:0] w_pc4, w_sel;
   beat_t           w_raw, w_new, w_out;
   beat_t           r_main, r_skid;
   logic            r_main_v, r_skid_v;
   always_comb begin
      w_eq    = in_rs1 == in_rs2;
      w_lt    = $signed(in_rs1) < $signed(in_rs2);
      w_ltu   = in_rs1 < in_rs2;
      w_taken = (in_funct3 == 3'b000) ? w_eq :
                (in_funct3 == 3'b001) ? !w_eq :
                (in_funct3 == 3'b100) ? w_lt :
                (in_funct3 == 3'b101) ? !w_lt :
                (in_funct3 == 3'b110) ? w_ltu :
                (in_funct3 == 3'b111) ? !w_ltu : 1'b0;
      w_sel   = (in_funct3 inside {3'b001, 3'b101}) ? shifter_rsv :
                (in_funct3 inside {3'b010, 3'b011}) ? comparator_rsv : adder_rsv;
      w_pc4   = in_pc + XLEN'(4);
      w_raw   = '0;
      w_raw.rd = in_rd;
      case (in_opcode)
         OP_OP, OP_IMM: w_raw.wdata = w_sel;
         OP_LUI:        w_raw.wdata = in_imm;
         OP_AUIPC:      w_raw.wdata = adder_rsv;
         OP_JAL: begin
            w_raw.wdata    = w_pc4;
            w_raw.target   = adder_rsv;
            w_raw.redirect = 1'b1;
         end
         OP_JALR: begin
            w_raw.wdata    = w_pc4;
            w_raw.target   = {adder_rsv[XLEN-1:1], 1'b0};
            w_raw.redirect = 1'b1;
         end
         OP_BRANCH: begin
            w_raw.target   = in_pc + in_imm;
            w_raw.redirect = w_taken;
         end
         default: w_raw.wdata = '0;
      endcase
      w_raw.we = (in_opcode inside {OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR}) && |in_rd;
   end
`ifdef ALU_RESULT_MISALIGN_TRAP_EN
   // A misaligned redirect becomes a trap: no write, no redirect, target kept for the handler.
   always_comb begin
      w_new      = w_raw;
      w_new.trap = w_raw.redirect && |w_raw.target[1:0];
      if (w_new.trap) begin
         w_new.we       = 1'b0;
         w_new.redirect = 1'b0;
      end
   end
`else
   assign w_new = w_raw;
`endif
   assign in_ready = !r_skid_v;
   assign w_accept = in_valid && in_ready;
   assign w_retire = r_main_v && out_ready;
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_main_v <= 1'b0;
         r_skid_v <= 1'b0;
         r_main   <= '0;
         r_skid   <= '0;
      end else if (!r_main_v || w_retire) begin
         if (r_skid_v) begin
            r_main   <= r_skid;
            r_skid_v <= 1'b0;
         end else begin
            r_main_v <= w_accept;
            if (w_accept) r_main <= w_new;
         end
      end else if (w_accept) begin
         r_skid   <= w_new;
         r_skid_v <= 1'b1;
      end
   end
   assign w_out        = r_main_v ? r_main : '0;
   assign out_valid    = r_main_v;
   assign out_rd       = w_out.rd;
   assign out_wdata    = w_out.wdata;
   assign out_we       = w_out.we;
   assign out_redirect = w_out.redirect;
   assign out_target   = w_out.target;
   assign out_trap     = w_out.trap;
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-to-writeback pipeline stage directly downstream of the ALU.
- Selects the architecturally correct result from the ALU's adder_rsv, shifter_rsv and comparator_rsv using the instruction's opcode and funct3.
- Resolves branches and jumps, producing redirect and target.
- Registers everything into a 2-entry skid buffer with a valid/ready handshake toward writeback.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  drops all buffered entries and the current input beat
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat
- in_opcode  input  7  RV32I opcode
- in_funct3  input  3  funct3 field
- in_rd  input  REG_ADDR_W  destination register
- in_pc  input  XLEN  instruction PC
- in_imm  input  XLEN  decoded immediate
- in_rs1  input  XLEN  rs1 value, used for branch compare
- in_rs2  input  XLEN  rs2 value, used for branch compare
- adder_rsv  input  XLEN  ALU adder result
- shifter_rsv  input  XLEN  ALU shifter result
- comparator_rsv  input  XLEN  ALU comparator result
- out_valid  output  1  output beat valid
- out_ready  input  1  writeback accepts the beat
- out_rd  output  REG_ADDR_W  destination register
- out_wdata  output  XLEN  writeback data
- out_we  output  1  register write enable; forced 0 when out_rd==0
- out_redirect  output  1  taken branch or jump
- out_target  output  XLEN  redirect target
- out_trap  output  1  misaligned target trap; see Optional Feature

Behaviour:
- Reset: synchronous on rst. Buffer is emptied. out_valid=0, in_ready=1. All other outputs are 0.
- Result select (combinational, applied to the captured beat):
  - OP (0110011) and OP-IMM (0010011), by funct3:
    - 000, 100, 110, 111 -> adder_rsv
    - 001, 101 -> shifter_rsv
    - 010, 011 -> comparator_rsv
  - LUI (0110111) -> in_imm.
  - AUIPC (0010111) -> adder_rsv.
  - JAL (1101111) -> wdata = in_pc+4; target = adder_rsv.
  - JALR (1100111) -> wdata = in_pc+4; target = adder_rsv with bit0 cleared.
  - BRANCH (1100011) -> we=0; target = in_pc+in_imm.
    - Taken condition, by funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
    - Compare uses in_rs1/in_rs2, not ALU outputs.
    - Funct3 010/011 -> not taken.
  - Any other opcode -> we=0, redirect=0, wdata=0.
- All additions are XLEN-bit and wrap modulo 2^XLEN (e.g. pc 0xFFFFFFFC + 4 = 0).
- Latency: an accepted beat appears on out_* the next cycle when the buffer was empty. Throughput is 1 beat/cycle while out_ready=1.
- Skid buffer: 2 entries, main and skid.
  - in_ready is registered: in_ready = skid entry empty.
  - Accept occurs when in_valid && in_ready. Retire occurs when out_valid && out_ready.
  - Empty, accept -> main loaded.
  - Main full, accept and retire in the same cycle -> main reloaded with the new beat.
  - Main full, accept without retire -> beat goes to skid; in_ready drops the next cycle.
  - Both full, retire -> skid moves to main; in_ready rises the next cycle.
- Outputs are driven only from main. They stay stable while out_valid && !out_ready.
- flush: both entries invalidated next cycle; an in_valid beat in the same cycle is discarded; out_valid=0 and in_ready=1 next cycle. flush has priority over accept and retire. rst has priority over flush.
- Reset or flush mid-stall discards stored beats; no partial beat is ever presented.

Optional Feature:
- Macro: ALU_RESULT_MISALIGN_TRAP_EN.
- Defined: on a captured beat with redirect=1 and target[1:0]!=0:
  - out_trap=1, out_we=0, out_redirect=0.
  - out_target still shows the offending address.
- Undefined: out_trap is tied 0 and the trap logic is absent; misaligned targets redirect normally.

Test Plan:
- OP funct3=101, shifter_rsv=0x0000000F, rd=5, out_ready=1 -> next cycle out_valid=1, out_wdata=0x0000000F, out_we=1, out_rd=5.
- BRANCH funct3=100, rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> out_redirect=1, out_target=0x120, out_we=0. Same with funct3=110 -> out_redirect=0.
- JALR adder_rsv=0x203, pc=0xFFFFFFFC:
  - Trap macro undefined -> out_target=0x202, out_wdata=0.
  - Trap macro defined -> out_trap=1, out_we=0.
- Backpressure: out_ready=0, three back-to-back beats A,B,C -> A held on outputs, B in skid, in_ready=0 on the cycle C is offered, so C is not accepted. Raise out_ready -> A, B, then C (after re-offer) in order, no loss or duplication.
- OP rd=0, adder_rsv=0x1234 -> out_valid=1, out_we=0.
- Both entries full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, the offered beat never appears. rst in the middle of a stall gives the same result.
